// File: rtl/state_sequencer_if.sv
// state_sequencer_if
//   Bundles the sequencer's step/feedback inputs and its status outputs.
//   master : the monitor/decoder side (drives en, rd, end_sq, halt)
//   slave  : the sequencer itself (drives state, halted, illegal, counters)
//   Signals:
//     en          step enable from the monitor
//     rd[7:0]     memory read data; opcode in rd[7:4] is used in F2
//     end_sq      decoder: last phase of the current sequence
//     halt        decoder: HALT instruction executing
//     state[11:0] registered control state (one-hot group + binary phase)
//     halted      registered, high while in HALT0
//     illegal     one-cycle pulse after an undefined opcode dispatch
//     cycle_count enabled non-halted cycles since reset
//     inst_count  retired instructions since reset
interface state_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [7:0]       rd;
  logic             end_sq;
  logic             halt;
  logic [11:0]      state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] inst_count;

  modport master (
    output en, rd, end_sq, halt,
    input  state, halted, illegal, cycle_count, inst_count
  );

  modport slave (
    input  en, rd, end_sq, halt,
    output state, halted, illegal, cycle_count, inst_count
  );
endinterface

// File: rtl/state_sequencer.sv
// state_sequencer
//   Control-state sequencer for the CDECv core. Produces the 12-bit state
//   vector consumed by the instruction decoder and advances it from the
//   decoder's end_sq/halt feedback and the opcode fetched in F2. Also keeps
//   run/halt status plus cycle and instruction counters for the monitor.
//   Ports:
//     clk    core clock, rising edge
//     reset  synchronous, active-high; overrides every other input
//     bus    state_sequencer_if.slave (see interface header for signals)
//   State encoding: state[11:4] one-hot group (bit4 R, bit5 F, bit6 MOV,
//   bit7 LD, bit8 ST, bit9 HALT, bits 10-11 always 0), state[3:0] phase.
module state_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  state_sequencer_if.slave    bus
);

  // Enum values are the architectural encoding, so the register drives
  // the state output directly with no decode.
  typedef enum logic [11:0] {
    S_R0    = 12'h010,
    S_F0    = 12'h020,
    S_F1    = 12'h021,
    S_F2    = 12'h022,
    S_MOV0  = 12'h040,
    S_LD0   = 12'h080,
    S_LD1   = 12'h081,
    S_LD2   = 12'h082,
    S_LD3   = 12'h083,
    S_LD4   = 12'h084,
    S_ST0   = 12'h100,
    S_ST1   = 12'h101,
    S_ST2   = 12'h102,
    S_ST3   = 12'h103,
    S_ST4   = 12'h104,
    S_HALT0 = 12'h200
  } state_t;

  state_t           state_q, state_d;
  state_t           nxt;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;

  logic             bad_op;   // undefined opcode dispatched from F2
  logic             retire;   // an instruction completes this cycle
  logic             in_exec;  // current state is in MOV, LD or ST group

  assign in_exec = state_q[6] | state_q[7] | state_q[8];

  // Next-state function, independent of en; en only gates the update.
  always_comb begin
    nxt    = state_q;
    bad_op = 1'b0;
    if (bus.halt) begin
      // halt wins over end_sq and over dispatch
      nxt = S_HALT0;
    end else begin
      unique case (state_q)
        S_R0:   nxt = S_F0;
        S_F0:   nxt = S_F1;
        S_F1:   nxt = S_F2;
        S_F2: begin
          case (bus.rd[7:4])
            4'h1:    nxt = S_MOV0;
            4'h2:    nxt = S_LD0;
            4'h3:    nxt = S_ST0;
            4'hF:    nxt = S_HALT0;
            default: begin
              nxt    = S_F0;
              bad_op = 1'b1;
            end
          endcase
        end
        // MOV has a single legal phase, so it always returns to fetch.
        S_MOV0: nxt = S_F0;
        S_LD0:  nxt = bus.end_sq ? S_F0 : S_LD1;
        S_LD1:  nxt = bus.end_sq ? S_F0 : S_LD2;
        S_LD2:  nxt = bus.end_sq ? S_F0 : S_LD3;
        S_LD3:  nxt = bus.end_sq ? S_F0 : S_LD4;
        S_LD4:  nxt = S_F0;   // last phase; guard back to fetch
        S_ST0:  nxt = bus.end_sq ? S_F0 : S_ST1;
        S_ST1:  nxt = bus.end_sq ? S_F0 : S_ST2;
        S_ST2:  nxt = bus.end_sq ? S_F0 : S_ST3;
        S_ST3:  nxt = bus.end_sq ? S_F0 : S_ST4;
        S_ST4:  nxt = S_F0;
        S_HALT0: nxt = S_HALT0;
        default: nxt = S_R0;  // recover from any unreachable encoding
      endcase
    end
  end

  // An illegal opcode counts as a retired instruction.
  assign retire = ~bus.halt & ((bus.end_sq & in_exec) | bad_op);

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = 1'b0;
    cyc_d     = cyc_q;
    inst_d    = inst_q;
    if (bus.en) begin
      state_d   = nxt;
      halted_d  = (nxt == S_HALT0);
      illegal_d = bad_op;
      if (state_q != S_HALT0) cyc_d = cyc_q + CNT_W'(1);
      if (retire)             inst_d = inst_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_R0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cyc_q     <= '0;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      cyc_q     <= cyc_d;
      inst_q    <= inst_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.cycle_count = cyc_q;
  assign bus.inst_count  = inst_q;

endmodule

// File: tb/tb_state_sequencer.sv
// tb_state_sequencer
//   Directed vector table, hand-written multi-cycle sequences and a random
//   run, all checked against a group/phase reference model.
module tb_state_sequencer;
  // Narrow counters so wrap-around is exercised during the random run.
  localparam int CNT_W = 5;

  localparam int G_R = 0, G_F = 1, G_MOV = 2, G_LD = 3, G_ST = 4, G_HALT = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  state_sequencer_if #(.CNT_W(CNT_W)) bus ();

  state_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: instruction group + phase number.
  int               m_group, m_phase;
  logic             m_halted, m_ill;
  logic [CNT_W-1:0] m_cyc, m_inst;

  function automatic int op_group(input logic [3:0] op);
    case (op)
      4'h1:    return G_MOV;
      4'h2:    return G_LD;
      4'h3:    return G_ST;
      4'hF:    return G_HALT;
      default: return -1;
    endcase
  endfunction

  function automatic logic [11:0] model_vec();
    logic [11:0] v;
    v = (12'h1 << (4 + m_group)) | 12'(m_phase);
    return v;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [7:0] d,
                            input logic es, input logic ht);
    int  ng, np, g, last;
    bit  ret;
    bit  ill;
    if (r) begin
      m_group = G_R; m_phase = 0; m_halted = 0; m_ill = 0; m_cyc = 0; m_inst = 0;
      return;
    end
    if (!e) begin
      m_ill = 0;
      return;
    end
    ng = m_group; np = m_phase; ret = 0; ill = 0;
    if (m_group != G_HALT) m_cyc = m_cyc + 1;
    if (ht) begin
      ng = G_HALT; np = 0;
    end else begin
      case (m_group)
        G_R: begin ng = G_F; np = 0; end
        G_F: begin
          if (m_phase < 2) np = m_phase + 1;
          else begin
            g = op_group(d[7:4]);
            if (g < 0) begin ng = G_F; np = 0; ill = 1; ret = 1; end
            else begin ng = g; np = 0; end
          end
        end
        G_MOV, G_LD, G_ST: begin
          last = (m_group == G_MOV) ? 0 : 4;
          if (es) begin ret = 1; ng = G_F; np = 0; end
          else if (m_phase == last) begin ng = G_F; np = 0; end
          else np = m_phase + 1;
        end
        default: ;
      endcase
    end
    m_group  = ng;
    m_phase  = np;
    m_ill    = ill;
    m_halted = (ng == G_HALT);
    if (ret) m_inst = m_inst + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one clock of inputs, update model, compare all outputs after edge.
  task automatic do_cycle(input logic r, input logic e, input logic [7:0] d,
                          input logic es, input logic ht);
    reset = r; bus.en = e; bus.rd = d; bus.end_sq = es; bus.halt = ht;
    @(posedge clk);
    model_step(r, e, d, es, ht);
    #1;
    chk("state",   32'(bus.state),       32'(model_vec()));
    chk("halted",  32'(bus.halted),      32'(m_halted));
    chk("illegal", 32'(bus.illegal),     32'(m_ill));
    chk("cycles",  32'(bus.cycle_count), 32'(m_cyc));
    chk("insts",   32'(bus.inst_count),  32'(m_inst));
    $display("cyc rst=%0b en=%0b rd=%02h es=%0b ht=%0b -> state=%03h hl=%0b il=%0b cc=%0d ic=%0d",
             r, e, d, es, ht, bus.state, bus.halted, bus.illegal, bus.cycle_count, bus.inst_count);
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst, en;
    logic [7:0]  rd;
    logic        es, ht;
    logic [11:0] st;
    logic        hl, il;
    int          cyc, inst;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic rst, input logic [7:0] rd, input logic es, input logic ht,
                      input logic [11:0] st, input logic hl, input logic il,
                      input int cyc, input int inst);
    vec_t v;
    v.rst = rst; v.en = 1'b1; v.rd = rd; v.es = es; v.ht = ht;
    v.st = st; v.hl = hl; v.il = il; v.cyc = cyc; v.inst = inst;
    vq.push_back(v);
  endtask

  initial begin
    reset = 1'b1; bus.en = 1'b0; bus.rd = 8'h00; bus.end_sq = 1'b0; bus.halt = 1'b0;
    m_group = G_R; m_phase = 0; m_halted = 0; m_ill = 0; m_cyc = 0; m_inst = 0;
    @(negedge clk);

    // ---- directed vector table: MOV, LD, illegal, LD guard, HALT ----
    addv(1, 8'h00, 0, 0, 12'h010, 0, 0, 0, 0);
    addv(1, 8'h00, 0, 0, 12'h010, 0, 0, 0, 0);
    addv(1, 8'h00, 0, 0, 12'h010, 0, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 12'h020, 0, 0, 1, 0);
    addv(0, 8'h00, 0, 0, 12'h021, 0, 0, 2, 0);
    addv(0, 8'h16, 0, 0, 12'h022, 0, 0, 3, 0);
    addv(0, 8'h16, 0, 0, 12'h040, 0, 0, 4, 0);
    addv(0, 8'h00, 1, 0, 12'h020, 0, 0, 5, 1);
    addv(0, 8'h00, 0, 0, 12'h021, 0, 0, 6, 1);
    addv(0, 8'h00, 0, 0, 12'h022, 0, 0, 7, 1);
    addv(0, 8'h23, 0, 0, 12'h080, 0, 0, 8, 1);
    addv(0, 8'h00, 0, 0, 12'h081, 0, 0, 9, 1);
    addv(0, 8'h00, 0, 0, 12'h082, 0, 0, 10, 1);
    addv(0, 8'h00, 0, 0, 12'h083, 0, 0, 11, 1);
    addv(0, 8'h00, 0, 0, 12'h084, 0, 0, 12, 1);
    addv(0, 8'h00, 1, 0, 12'h020, 0, 0, 13, 2);
    addv(0, 8'h00, 0, 0, 12'h021, 0, 0, 14, 2);
    addv(0, 8'h00, 0, 0, 12'h022, 0, 0, 15, 2);
    addv(0, 8'h70, 0, 0, 12'h020, 0, 1, 16, 3);
    addv(0, 8'h00, 0, 0, 12'h021, 0, 0, 17, 3);
    addv(0, 8'h00, 0, 0, 12'h022, 0, 0, 18, 3);
    addv(0, 8'h23, 0, 0, 12'h080, 0, 0, 19, 3);
    addv(0, 8'h00, 0, 0, 12'h081, 0, 0, 20, 3);
    addv(0, 8'h00, 0, 0, 12'h082, 0, 0, 21, 3);
    addv(0, 8'h00, 0, 0, 12'h083, 0, 0, 22, 3);
    addv(0, 8'h00, 0, 0, 12'h084, 0, 0, 23, 3);
    addv(0, 8'h00, 0, 0, 12'h020, 0, 0, 24, 3);
    addv(0, 8'h00, 0, 0, 12'h021, 0, 0, 25, 3);
    addv(0, 8'h00, 0, 0, 12'h022, 0, 0, 26, 3);
    addv(0, 8'hF0, 0, 0, 12'h200, 1, 0, 27, 3);
    addv(0, 8'h00, 1, 1, 12'h200, 1, 0, 27, 3);

    for (int i = 0; i < vq.size(); i++) begin
      do_cycle(vq[i].rst, vq[i].en, vq[i].rd, vq[i].es, vq[i].ht);
      chk($sformatf("vec%0d_state", i), 32'(bus.state),       32'(vq[i].st));
      chk($sformatf("vec%0d_halt", i),  32'(bus.halted),      32'(vq[i].hl));
      chk($sformatf("vec%0d_ill", i),   32'(bus.illegal),     32'(vq[i].il));
      chk($sformatf("vec%0d_cyc", i),   32'(bus.cycle_count), 32'(vq[i].cyc));
      chk($sformatf("vec%0d_inst", i),  32'(bus.inst_count),  32'(vq[i].inst));
    end

    // ---- HALT is sticky for 20 cycles whatever the inputs ----
    for (int i = 0; i < 20; i++) begin
      do_cycle(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      chk("halt_hold_state", 32'(bus.state),       32'h200);
      chk("halt_hold_cyc",   32'(bus.cycle_count), 32'd27);
      chk("halt_hold_inst",  32'(bus.inst_count),  32'd3);
    end
    do_cycle(1, 1, 8'h00, 0, 0);
    chk("halt_reset_state", 32'(bus.state), 32'h010);

    // ---- ST with en low for 2 cycles in ST2 ----
    do_cycle(0, 1, 8'h00, 0, 0);            // F0, cycle_count 1
    do_cycle(0, 1, 8'h00, 0, 0);            // F1
    do_cycle(0, 1, 8'h35, 0, 0);            // F2
    do_cycle(0, 1, 8'h35, 0, 0);            // ST0
    do_cycle(0, 1, 8'h00, 0, 0);            // ST1
    do_cycle(0, 1, 8'h00, 0, 0);            // ST2
    for (int i = 0; i < 2; i++) begin
      do_cycle(0, 0, 8'h00, 1, 0);
      chk("st_hold_state", 32'(bus.state),       32'h102);
      chk("st_hold_cyc",   32'(bus.cycle_count), 32'd6);
    end
    do_cycle(0, 1, 8'h00, 0, 0);            // ST3
    do_cycle(0, 1, 8'h00, 0, 0);            // ST4
    do_cycle(0, 1, 8'h00, 1, 0);            // F0
    chk("st_done_state", 32'(bus.state),       32'h020);
    chk("st_done_cyc",   32'(bus.cycle_count), 32'd9);
    chk("st_done_inst",  32'(bus.inst_count),  32'd1);

    // ---- reset mid-LD with end_sq: no partial retire ----
    do_cycle(0, 1, 8'h00, 0, 0);
    do_cycle(0, 1, 8'h2A, 0, 0);
    do_cycle(0, 1, 8'h2A, 0, 0);            // LD0
    do_cycle(0, 1, 8'h00, 0, 0);            // LD1
    do_cycle(1, 1, 8'h00, 1, 0);
    chk("midrst_state", 32'(bus.state),      32'h010);
    chk("midrst_inst",  32'(bus.inst_count), 32'd0);

    // ---- simultaneous end_sq and halt in ST1 ----
    do_cycle(0, 1, 8'h00, 0, 0);            // F0
    do_cycle(0, 1, 8'h00, 0, 0);            // F1
    do_cycle(0, 1, 8'h3C, 0, 0);            // F2
    do_cycle(0, 1, 8'h3C, 0, 0);            // ST0
    do_cycle(0, 1, 8'h00, 0, 0);            // ST1
    do_cycle(0, 1, 8'h00, 1, 1);
    chk("eshalt_state", 32'(bus.state),      32'h200);
    chk("eshalt_hl",    32'(bus.halted),     32'd1);
    chk("eshalt_inst",  32'(bus.inst_count), 32'd0);

    // ---- randomized run against the model ----
    do_cycle(1, 1, 8'h00, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 3));
      do_cycle(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 9) != 0),
               {op, 4'($urandom)}, 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
